// File: rtl/fanin_merge_pkg.sv
// fanin_pkg: shared types and helpers for the fanin_merge stream merger.
//   merge_state_e : arbiter state (idle / locked to one source for a packet)
//   FM_*          : default configuration widths
//   FM_EOP_BIT    : end-of-packet flag position in the default token
//   buf_entry_t   : output buffer entry {data, src} at default widths
//   wrap_inc      : modulo-n increment for round-robin pointers
package fanin_pkg;

  localparam int FM_NUM_IN = 9;
  localparam int FM_DATA_W = 17;
  localparam int FM_SRC_W  = $clog2(FM_NUM_IN);
  localparam int FM_EOP_BIT = FM_DATA_W - 1;

  typedef enum logic {
    MRG_IDLE   = 1'b0,
    MRG_LOCKED = 1'b1
  } merge_state_e;

  typedef struct packed {
    logic [FM_DATA_W-1:0] data;
    logic [FM_SRC_W-1:0]  src;
  } buf_entry_t;

  function automatic int wrap_inc(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fanin_merge_if.sv
// fanin_merge_if: bundle of the NUM_IN upstream streams and the single
// downstream stream of the merger.
//   in_valid/in_data/in_ready    : per-input valid/ready streams
//   out_valid/out_data/out_src   : merged stream head and its source index
//   out_ready                    : downstream accept
// master = stream producer/consumer side (environment), slave = merger.
interface fanin_merge_if #(
  parameter int NUM_IN = 9,
  parameter int DATA_W = 17,
  parameter int SRC_W  = $clog2(NUM_IN)
);
  logic [NUM_IN-1:0]             in_valid;
  logic [NUM_IN-1:0][DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]             in_ready;
  logic                          out_valid;
  logic [DATA_W-1:0]             out_data;
  logic [SRC_W-1:0]              out_src;
  logic                          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/fanin_merge_rr_pick.sv
// rr_pick: combinational round-robin first-one finder.
//   req   : request vector
//   ptr   : highest-priority index; search runs ptr, ptr+1, ... wrapping mod N
//   grant : index of the first set request found
//   found : 1 when any request is set
module rr_pick #(
  parameter int N     = 9,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             found
);

  logic [PTR_W-1:0] idx;
  int               sum;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int k = 0; k < N; k++) begin
      sum = (int'(ptr) + k) % N;
      idx = PTR_W'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/fanin_merge.sv
// fanin_merge: round-robin, packet-locked merge of NUM_IN streams into one,
// decoupled from the downstream by a 2-entry {data, src} buffer.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous clear of buffer, lock and round-robin pointer
//   en_mask   : per-input participation enable (quasi-static)
//   bus       : fanin_merge_if slave (upstream streams + downstream stream)
// Token bit DATA_W-1 is the end-of-packet flag.
module fanin_merge
  import fanin_pkg::*;
#(
  parameter int NUM_IN = FM_NUM_IN,
  parameter int DATA_W = FM_DATA_W,
  parameter int SRC_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NUM_IN-1:0] en_mask,
  fanin_merge_if.slave      bus
);

  localparam int EOP_BIT = DATA_W - 1;

  // Entry shaped by this instance's parameters (buf_entry_t is the default-width form).
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } entry_t;

  merge_state_e      state_q, state_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]        count_q, count_d;
  entry_t            ent0_q, ent0_d;
  entry_t            ent1_q, ent1_d;

  logic [NUM_IN-1:0] elig;
  logic [NUM_IN-1:0] in_ready;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  push_src;
  logic              found;
  logic              space;
  logic              push;
  logic              pop;
  logic              push_eop;
  entry_t            push_ent;

  assign elig  = bus.in_valid & en_mask;
  // Space comes only from registered count, so in_ready never sees out_ready.
  assign space = (count_q != 2'd2);

  rr_pick #(
    .N     (NUM_IN),
    .PTR_W (SRC_W)
  ) u_rr_pick (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .found (found)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MRG_IDLE;
      src_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FSM output: per-input ready. Reset and flush both suppress acceptance
  // so an upstream token offered then is held, not silently dropped.
  always_comb begin
    in_ready = '0;
    if (!rst && !flush && space) begin
      if (state_q == MRG_IDLE) begin
        if (found) in_ready[grant] = 1'b1;
      end else begin
        in_ready[src_q] = en_mask[src_q];
      end
    end
  end

  assign bus.in_ready = in_ready;

  always_comb begin
    push_src      = (state_q == MRG_IDLE) ? grant : src_q;
    push          = |(in_ready & bus.in_valid);
    push_ent.data = bus.in_data[push_src];
    push_ent.src  = push_src;
    push_eop      = push_ent.data[EOP_BIT];
    pop           = (count_q != 2'd0) && bus.out_ready;
  end

  // FSM next state
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      state_d  = MRG_IDLE;
      src_d    = '0;
      rr_ptr_d = '0;
    end else begin
      unique case (state_q)
        MRG_IDLE: begin
          if (push) begin
            rr_ptr_d = SRC_W'(wrap_inc(int'(grant), NUM_IN));
            if (!push_eop) begin
              state_d = MRG_LOCKED;
              src_d   = grant;
            end
          end
        end
        MRG_LOCKED: begin
          // A source disabled mid-packet releases the lock without a push.
          if (!en_mask[src_q]) begin
            state_d = MRG_IDLE;
          end else if (push && push_eop) begin
            state_d  = MRG_IDLE;
            rr_ptr_d = SRC_W'(wrap_inc(int'(src_q), NUM_IN));
          end
        end
        default: state_d = MRG_IDLE;
      endcase
    end
  end

  // Output buffer: ent0 is always the head; pops shift ent1 down.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush) begin
      count_d = 2'd0;
      ent0_d  = '0;
      ent1_d  = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = push_ent;
          else                 ent1_d = push_ent;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Push needs space, so count is 1 here in practice.
          if (count_q == 2'd1) begin
            ent0_d = push_ent;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = ent0_q.data;
  assign bus.out_src   = ent0_q.src;

endmodule

// File: doc/fanin_merge.md
# fanin_merge

Multi-producer to single-consumer stream merger for the onyx stream fabric. It collects tokens from up to NUM_IN upstream valid/ready streams and issues them on one downstream stream. Arbitration is round-robin and packet-locked, so a packet is never interleaved with another source. A 2-entry output buffer decouples every input ready from the downstream ready. It is the fan-in counterpart of the fanout ready-aggregation logic, and sits wherever several primitives feed one consumer.

## Interface
Parameters:
- NUM_IN, 9, number of input streams (2..16)
- DATA_W, 17, token width; bit DATA_W-1 = end-of-packet (EOP) flag
- SRC_W, $clog2(NUM_IN), width of source index

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of buffer, lock and pointer (same end state as rst)
- en_mask  in  NUM_IN  config; input i participates only when en_mask[i]=1; quasi-static
- in_valid  in  NUM_IN  per-input token valid
- in_data  in  NUM_IN×DATA_W  per-input token
- in_ready  out  NUM_IN  per-input accept
- out_valid  out  1  buffer head valid
- out_data  out  DATA_W  buffer head token
- out_src  out  SRC_W  index of the input the head token came from
- out_ready  in  1  downstream accept

## Operation
- Eligible input: in_valid[i] & en_mask[i]. Disabled inputs always see in_ready[i]=0.
- Buffer: 2-entry FIFO holding {data, src}. Registered count 0..2. space = (count<2), computed from registers only.
- State IDLE:
  - Grant the first eligible input at or after rr_ptr, wrapping modulo NUM_IN.
  - If space, assert in_ready[grant] only. The handshake pushes the token.
  - Non-EOP token: go to LOCKED(src=grant).
  - EOP token: stay IDLE.
  - After every accepted grant, rr_ptr <= grant+1, wrapping to 0 past NUM_IN-1.
- State LOCKED(src):
  - Only input src is served, with in_ready[src]=space. Other inputs are ignored even if valid.
  - An accepted EOP token returns the block to IDLE with rr_ptr <= src+1.
  - If en_mask[src] drops while LOCKED, return to IDLE next cycle. No token is pushed for src.
- Downstream: a pop occurs when out_valid & out_ready. Push and pop in the same cycle leave count unchanged. Push at count=2 is impossible by construction.
- Order: tokens leave in exactly the order they were accepted.
- No eligible input in IDLE: all in_ready=0; rr_ptr unchanged.

## Timing
- Reset/flush values: count=0, state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_src=0, in_ready=0.
- Latency: a token accepted in cycle t appears on out_data in cycle t+1 when the buffer was empty.
- Throughput: 1 token/cycle sustained while out_ready=1.
- Full buffer (count=2): all in_ready=0. The head is held stable, with out_valid held, until popped.
- in_ready depends on in_valid, en_mask and registered state only. There is no combinational path from out_ready.
- Reset asserted mid-packet drops the buffer and lock immediately. Upstream holds its valid token, and it is re-arbitrated from rr_ptr=0.
- flush and a handshake in the same cycle: flush wins and the token is not pushed. in_ready is forced to 0 while flush=1.

## Structure
- Shared package fanin_pkg:
  - merge_state_e enum {MRG_IDLE, MRG_LOCKED}
  - EOP bit-index constant
  - buffer entry struct {data, src}
- Sub-module rr_pick: combinational round-robin first-one finder (mask, ptr -> grant, found). Reused by future arbiters.
- Top level holds the FSM, rr_ptr and the 2-entry buffer.

## Test plan
- Single source: input 3 sends 0x00005, 0x00006, then 0x10007 (EOP), out_ready=1 -> out_data has the same three values on consecutive cycles starting t+1; out_src=3 each time.
- Packet lock: inputs 0 and 1 both valid. Input 0 sends a 3-token packet, with EOP on the 3rd -> all three input-0 tokens precede any input-1 token, then input 1 is granted.
- Round-robin fairness: inputs 0, 2 and 5 all valid with single-token EOP packets, continuously -> grant order 0,2,5,0,2,5…
- Backpressure: out_ready=0 for 5 cycles with a source valid -> exactly 2 tokens accepted; in_ready=0 afterwards. Releasing out_ready drains them in order with no loss or duplication.
- Masking: en_mask=9'h0FE with input 0 valid -> in_ready[0]=0 and no output. Clearing en_mask[src] mid-packet -> state returns to IDLE and other inputs are served.
- Reset and flush mid-packet: rst (async) while count=2 and LOCKED -> out_valid=0 immediately. flush does the same on the next edge, and the next arbitration starts at input 0.
